// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared types and helpers for the UART transmit scheduler
package uart_sched_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  localparam int MAX_REQ = 8;

  // Assumes a one-hot (or all-zero) input; all-zero maps to index 0.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter with optional strict priority for slot 0
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  input  logic             prio0,
  output logic [NREQ-1:0]  win,
  output logic [PTR_W-1:0] win_idx
);

  logic [MAX_REQ-1:0] win_ext;

  // Outer loop walks the search order from ptr; inner loop keeps every select index constant.
  always_comb begin
    logic found;
    win   = '0;
    found = 1'b0;
    if (prio0 && req[0]) begin
      win[0] = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
            win[i] = 1'b1;
            found  = 1'b1;
          end
        end
      end
    end
  end

  assign win_ext = MAX_REQ'(win);
  assign win_idx = PTR_W'(onehot_to_idx(win_ext));

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - packet-locked arbiter sharing one uart_tx link among several byte streams
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int PRIO0   = 1,
  parameter int TIMEOUT = 50000,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              abort,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int               PTR_W    = $clog2(NREQ);
  localparam int               TMR_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_d, win;
  logic [PTR_W-1:0] g_idx_q, g_idx_d, rr_ptr_q, rr_ptr_d, win_idx, next_ptr;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] pkt_count_d;
  logic             abort_d;
  logic             xfer, cur_valid, cur_last;
  logic [7:0]       cur_data;

  rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .prio0   (PRIO0 != 0),
    .win     (win),
    .win_idx (win_idx)
  );

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        cur_valid = cur_valid | req_valid[i];
        cur_last  = cur_last | req_last[i];
        cur_data  = cur_data | req_data[8*i +: 8];
      end
    end
  end

  assign busy      = (state_q == S_OWN);
  assign tx_valid  = busy & cur_valid;
  assign tx_data   = cur_data;
  assign req_ready = grant & {NREQ{busy & tx_ready}};
  assign xfer      = tx_valid & tx_ready;
  assign next_ptr  = (int'(g_idx_q) == NREQ - 1) ? '0 : g_idx_q + PTR_W'(1);

  // Timer only advances while the owner has nothing to offer; UART backpressure is not a stall.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant;
    g_idx_d     = g_idx_q;
    rr_ptr_d    = rr_ptr_q;
    timer_d     = timer_q;
    pkt_count_d = pkt_count;
    abort_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          state_d = S_OWN;
          grant_d = win;
          g_idx_d = win_idx;
          timer_d = '0;
        end
      end
      S_OWN: begin
        if (xfer) begin
          timer_d = '0;
          if (cur_last) begin
            pkt_count_d = pkt_count + CNT_W'(1);
            rr_ptr_d    = next_ptr;
            grant_d     = '0;
            state_d     = S_IDLE;
          end
        end else if (!cur_valid) begin
          if (timer_q == TMR_LAST) begin
            abort_d  = 1'b1;
            rr_ptr_d = next_ptr;
            grant_d  = '0;
            timer_d  = '0;
            state_d  = S_IDLE;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      grant     <= '0;
      g_idx_q   <= '0;
      rr_ptr_q  <= '0;
      timer_q   <= '0;
      pkt_count <= '0;
      abort     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant     <= grant_d;
      g_idx_q   <= g_idx_d;
      rr_ptr_q  <= rr_ptr_d;
      timer_q   <= timer_d;
      pkt_count <= pkt_count_d;
      abort     <= abort_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid, req_last;
  logic [23:0] req_data;
  logic        tx_ready;

  logic [2:0]  p_req_ready, p_grant;
  logic [7:0]  p_tx_data;
  logic        p_tx_valid, p_busy, p_abort;
  logic [15:0] p_pkt;

  logic [2:0]  r_req_ready, r_grant;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid, r_busy, r_abort;
  logic [1:0]  r_pkt;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  uart_tx_scheduler #(.NREQ(3), .PRIO0(1), .TIMEOUT(8), .CNT_W(16)) dut_p (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(p_req_ready), .tx_data(p_tx_data),
    .tx_valid(p_tx_valid), .tx_ready(tx_ready), .grant(p_grant), .busy(p_busy),
    .abort(p_abort), .pkt_count(p_pkt)
  );

  uart_tx_scheduler #(.NREQ(3), .PRIO0(0), .TIMEOUT(8), .CNT_W(2)) dut_r (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(r_req_ready), .tx_data(r_tx_data),
    .tx_valid(r_tx_valid), .tx_ready(tx_ready), .grant(r_grant), .busy(r_busy),
    .abort(r_abort), .pkt_count(r_pkt)
  );

  typedef struct {
    logic [2:0]  rv;
    logic [7:0]  d0, d1, d2;
    logic [2:0]  rl;
    logic        tr;
    logic [2:0]  eg;
    logic        etv;
    logic [7:0]  etd;
    logic [2:0]  err;
    logic        eb;
    logic [15:0] ep;
  } vec_t;

  vec_t tbl[13];
  int   rr_grant[9];
  int   rr_pkt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] rv, input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [2:0] rl, input logic tr);
    @(negedge clk);
    req_valid = rv;
    req_data  = {d2, d1, d0};
    req_last  = rl;
    tx_ready  = tr;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;

    // rv, d0, d1, d2, rl, tr | grant, tx_valid, tx_data, req_ready, busy, pkt_count
    tbl[0]  = '{3'b010, 8'h00, 8'h46, 8'h00, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 16'd0};
    tbl[1]  = '{3'b010, 8'h00, 8'h46, 8'h00, 3'b000, 1'b1, 3'b010, 1'b1, 8'h46, 3'b010, 1'b1, 16'd0};
    tbl[2]  = '{3'b010, 8'h00, 8'h42, 8'h00, 3'b010, 1'b1, 3'b010, 1'b1, 8'h42, 3'b010, 1'b1, 16'd0};
    tbl[3]  = '{3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 16'd1};
    tbl[4]  = '{3'b111, 8'hA0, 8'hB0, 8'hC0, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 16'd1};
    tbl[5]  = '{3'b111, 8'hA0, 8'hB0, 8'hC0, 3'b000, 1'b1, 3'b001, 1'b1, 8'hA0, 3'b001, 1'b1, 16'd1};
    tbl[6]  = '{3'b111, 8'hA1, 8'hB0, 8'hC0, 3'b000, 1'b1, 3'b001, 1'b1, 8'hA1, 3'b001, 1'b1, 16'd1};
    tbl[7]  = '{3'b111, 8'hA2, 8'hB0, 8'hC0, 3'b001, 1'b1, 3'b001, 1'b1, 8'hA2, 3'b001, 1'b1, 16'd1};
    tbl[8]  = '{3'b110, 8'h00, 8'hB0, 8'hC0, 3'b110, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 16'd2};
    tbl[9]  = '{3'b110, 8'h00, 8'hB0, 8'hC0, 3'b110, 1'b1, 3'b010, 1'b1, 8'hB0, 3'b010, 1'b1, 16'd2};
    tbl[10] = '{3'b100, 8'h00, 8'h00, 8'hC0, 3'b100, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 16'd3};
    tbl[11] = '{3'b100, 8'h00, 8'h00, 8'hC0, 3'b100, 1'b1, 3'b100, 1'b1, 8'hC0, 3'b100, 1'b1, 16'd3};
    tbl[12] = '{3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 3'b000, 1'b0, 16'd4};

    rr_grant = '{0, 1, 0, 4, 0, 1, 0, 4, 0};
    rr_pkt   = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

    do_reset();
    chk("rst_p_grant", 32'(p_grant), 0);
    chk("rst_p_busy", 32'(p_busy), 0);
    chk("rst_p_abort", 32'(p_abort), 0);
    chk("rst_p_pkt", 32'(p_pkt), 0);
    chk("rst_p_tx_valid", 32'(p_tx_valid), 0);
    chk("rst_p_req_ready", 32'(p_req_ready), 0);
    chk("rst_r_grant", 32'(r_grant), 0);
    chk("rst_r_pkt", 32'(r_pkt), 0);

    // Single packet from req1, then a three-way priority race.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rv, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].rl, tbl[i].tr);
      chk($sformatf("tbl%0d_grant", i), 32'(p_grant), 32'(tbl[i].eg));
      chk($sformatf("tbl%0d_tx_valid", i), 32'(p_tx_valid), 32'(tbl[i].etv));
      chk($sformatf("tbl%0d_req_ready", i), 32'(p_req_ready), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_busy", i), 32'(p_busy), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d_pkt", i), 32'(p_pkt), 32'(tbl[i].ep));
      if (tbl[i].etv) chk($sformatf("tbl%0d_tx_data", i), 32'(p_tx_data), 32'(tbl[i].etd));
    end

    // Round-robin fairness on the no-priority instance; 2-bit counter wraps after 4 packets.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      if (k < 8) step(3'b101, 8'h10, 8'h00, 8'h30, 3'b101, 1'b1);
      else       step(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
      chk($sformatf("rr%0d_grant", k), 32'(r_grant), 32'(rr_grant[k]));
      chk($sformatf("rr%0d_tx_valid", k), 32'(r_tx_valid), 32'(rr_grant[k] != 0));
      chk($sformatf("rr%0d_pkt", k), 32'(r_pkt), 32'(rr_pkt[k]));
    end

    // UART backpressure held well past TIMEOUT must not abort.
    do_reset();
    step(3'b010, 8'h00, 8'h55, 8'h00, 3'b010, 1'b0);
    chk("bp_idle_grant", 32'(p_grant), 0);
    for (int k = 0; k < 20; k++) begin
      step(3'b010, 8'h00, 8'h55, 8'h00, 3'b010, 1'b0);
      chk($sformatf("bp%0d_abort", k), 32'(p_abort), 0);
      chk($sformatf("bp%0d_grant", k), 32'(p_grant), 2);
      chk($sformatf("bp%0d_req_ready", k), 32'(p_req_ready), 0);
    end
    step(3'b010, 8'h00, 8'h55, 8'h00, 3'b010, 1'b1);
    chk("bp_release_req_ready", 32'(p_req_ready), 2);
    chk("bp_release_tx_data", 32'(p_tx_data), 32'h55);
    step(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
    chk("bp_done_pkt", 32'(p_pkt), 1);
    chk("bp_done_grant", 32'(p_grant), 0);

    // Stall: req2 sends one non-last byte then goes silent while req0 waits.
    do_reset();
    step(3'b100, 8'h00, 8'h00, 8'h77, 3'b000, 1'b1);
    chk("st_idle_grant", 32'(p_grant), 0);
    step(3'b100, 8'h00, 8'h00, 8'h77, 3'b000, 1'b1);
    chk("st_own_tx_data", 32'(p_tx_data), 32'h77);
    for (int j = 1; j <= 9; j++) begin
      step(3'b001, 8'h99, 8'h00, 8'h00, 3'b001, 1'b1);
      chk($sformatf("st%0d_abort", j), 32'(p_abort), 32'(j == 9));
      chk($sformatf("st%0d_grant", j), 32'(p_grant), (j == 9) ? 0 : 4);
    end
    chk("st_abort_pkt", 32'(p_pkt), 0);
    step(3'b001, 8'h99, 8'h00, 8'h00, 3'b001, 1'b1);
    chk("st_next_abort", 32'(p_abort), 0);
    chk("st_next_grant", 32'(p_grant), 1);
    chk("st_next_tx_data", 32'(p_tx_data), 32'h99);
    step(3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1);
    chk("st_final_pkt", 32'(p_pkt), 1);

    // Asynchronous reset mid-packet; pointer must restart at 0.
    do_reset();
    step(3'b010, 8'h00, 8'h11, 8'h00, 3'b010, 1'b1);
    step(3'b010, 8'h00, 8'h11, 8'h00, 3'b010, 1'b1);
    chk("ar_first_grant", 32'(r_grant), 2);
    step(3'b110, 8'h00, 8'h21, 8'h31, 3'b000, 1'b1);
    chk("ar_pkt_before", 32'(r_pkt), 1);
    step(3'b110, 8'h00, 8'h21, 8'h31, 3'b000, 1'b1);
    chk("ar_own_grant", 32'(r_grant), 4);
    chk("ar_own_busy", 32'(r_busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_rst_grant", 32'(r_grant), 0);
    chk("ar_rst_busy", 32'(r_busy), 0);
    chk("ar_rst_tx_valid", 32'(r_tx_valid), 0);
    chk("ar_rst_req_ready", 32'(r_req_ready), 0);
    chk("ar_rst_pkt", 32'(r_pkt), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step(3'b110, 8'h00, 8'h21, 8'h31, 3'b000, 1'b1);
    chk("ar_restart_grant", 32'(r_grant), 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
